// File: rtl/mmio_fifo_ctrl.sv
// MMIO-mapped 64-bit FIFO with DATA/STATUS/CTRL/PEEK registers and a registered, TID-tagged read response.
// Define MMIO_FIFO_PEEK_EN to decode the non-popping PEEK register at BASE_ADDR+6.
module mmio_fifo_ctrl #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [15:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic        rd_valid,
  input  logic [15:0] rd_addr,
  input  logic [8:0]  rd_tid,
  output logic        hit,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rsp_valid_q;
  logic [8:0]    rsp_tid_q;
  logic [63:0]   rsp_data_q, rsp_data_d;

  logic wr_dat, wr_ctl;
  logic rd_dat, rd_sts, rd_ctl, rd_pk;
  logic push, pop;
  logic [63:0] head;

  assign wr_dat = wr_valid && (wr_addr == BASE_ADDR);
  assign wr_ctl = wr_valid && (wr_addr == BASE_ADDR + 16'd4);
  assign rd_dat = rd_valid && (rd_addr == BASE_ADDR);
  assign rd_sts = rd_valid && (rd_addr == BASE_ADDR + 16'd2);
  assign rd_ctl = rd_valid && (rd_addr == BASE_ADDR + 16'd4);
`ifdef MMIO_FIFO_PEEK_EN
  assign rd_pk  = rd_valid && (rd_addr == BASE_ADDR + 16'd6);
`else
  assign rd_pk  = 1'b0;
`endif

  assign hit   = rd_dat | rd_sts | rd_ctl | rd_pk;
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rptr_q];

  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  assign pop  = rd_dat && !empty;
  assign push = wr_dat && (!full || rd_dat);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rsp_data_d = '0;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Clear first so a same-cycle event keeps its flag set.
    if (wr_ctl && wr_data[1]) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_dat && full && !rd_dat) ovf_d = 1'b1;
    if (rd_dat && empty)           udf_d = 1'b1;
    if (wr_ctl && wr_data[0]) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
    unique case (1'b1)
      rd_dat:  rsp_data_d = pop ? head : '0;
      rd_sts:  rsp_data_d = {48'b0, 8'(cnt_q), 4'b0,
                             ovf_q, udf_q, full, empty};
      rd_pk:   rsp_data_d = empty ? '0 : head;
      default: rsp_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      rsp_valid_q <= hit;
      if (hit) begin
        rsp_tid_q  <= rd_tid;
        rsp_data_q <= rsp_data_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_data  = rsp_data_q;

endmodule
